sr04_scan_ctrl: RTL and testbench
=================================

Name: sr04_scan_ctrl

Overview:
- Round-robin scheduler for up to NUM_SENS HC-SR04 ultrasonic sensors that share one echo-width timer.
- For each enabled sensor in turn, it issues a trigger pulse, measures the echo high time in microseconds, and enforces a timeout and an inter-ping gap.
- It publishes one tagged 19-bit result per measurement, for the seg/uart/led consumers.
- It replaces free-running per-sensor trig/echo drivers when more than one sensor is fitted.

Parameters:
- CLK_FREQ, 50000000, system clock in Hz; the 1 us tick divisor is CLK_FREQ/1000000.
- NUM_SENS, 4, number of sensors, 1..8.
- TRIG_US, 10, trigger pulse width in us.
- TIMEOUT_US, 30000, maximum wait for echo rise, and maximum echo high time, in us.
- GAP_US, 60000, minimum time in us from one trigger start to the next trigger start (any sensor).

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous reset, ACTIVE-HIGH (asserted = 1), despite the name.
- en  in  1  scan enable; 0 parks the FSM in IDLE after the current slot completes.
- sens_mask  in  NUM_SENS  1 = sensor included in the scan; sampled when a sensor is selected.
- echo  in  NUM_SENS  raw echo inputs, asynchronous.
- trig  out  NUM_SENS  trigger outputs, one-hot or zero.
- dist_data  out  19  echo high time in us, saturating.
- dist_id  out  3  index of the sensor that produced dist_data.
- dist_valid  out  1  one-cycle strobe; dist_data/dist_id are valid in this cycle and held until the next strobe.
- timeout  out  1  sticky flag; set on any timeout, cleared on the next successful dist_valid.
- busy  out  1  1 whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, rstn=1): all outputs 0, FSM=IDLE, pointer=0, counters=0, echo synchronisers=0.
- Tick: a free-running divider pulses us_tick for 1 clk every CLK_FREQ/1e6 clocks. All us counters advance only on us_tick.
- Echo sync: 2-flop synchroniser per bit. Only the selected sensor's synchronised echo is used; edge detection uses a third registered copy.
- FSM:
  - IDLE: if en=1 and sens_mask≠0, select the next set mask bit at or after pointer (wrapping modulo NUM_SENS), reset gap_cnt and us_cnt, then go to TRIG. Otherwise stay in IDLE.
  - TRIG: trig[sel]=1 for exactly TRIG_US ticks (±1 tick of alignment), then go to WAIT_RISE.
  - WAIT_RISE: on an echo rising edge, clear us_cnt and go to MEASURE. If us_cnt reaches TIMEOUT_US, take the timeout path and go to GAP.
  - MEASURE: count us while echo is high. On the falling edge, go to STORE. If us_cnt reaches TIMEOUT_US, take the timeout path and go to GAP.
  - STORE: one cycle; dist_data=us_cnt (saturated at 2^19-1), dist_id=sel, dist_valid=1, timeout<=0. Go to GAP.
  - GAP: wait until gap_cnt (counting since TRIG entry) ≥ GAP_US. Then set pointer=sel+1 mod NUM_SENS and go to IDLE. Re-arbitration happens the next cycle.
- Timeout path: set the timeout flag and do not update dist_data or dist_id. Optional Feature may also strobe.
- Mask handling:
  - A sens_mask change mid-slot does not abort the slot.
  - A sens_mask of all zeros keeps the FSM in IDLE, and busy=0.
- en deassert mid-slot: the slot completes, including GAP. After that the FSM stays in IDLE.
- Simultaneous events: an echo edge and the timeout limit on the same tick → the edge wins.
- An echo already high when entering WAIT_RISE is not treated as a rise. A true 0→1 transition is required.
- Reset mid-slot: trig drops immediately (asynchronously), and no dist_valid is produced.
- Result latency: dist_valid is asserted 4 clocks after the raw echo falls: 2 sync + 1 edge + 1 STORE.

Optional Feature:
- Macro: SR04_TIMEOUT_REPORT_EN.
- Defined: the timeout path also outputs dist_data=19'h7FFFF, dist_id=sel and dist_valid=1 for one cycle (timeout set in the same cycle), so consumers see "out of range".
- Undefined: a timeout only sets the sticky flag, and no strobe is generated.

Test Plan:
- CLK_FREQ=1e6, NUM_SENS=4, mask=4'b1111, en=1; echo[0] high 1160 us after its rise → trig[0] pulses 10 us; dist_valid with dist_data=1160 (±1), dist_id=0; next trigger is trig[1], 60000 us after trig[0] start.
- mask=4'b1010 → trigger order 1,3,1,3; trig[0] and trig[2] are never asserted.
- Sensor 2 never echoes → after 30000 us, timeout=1. With the macro: dist_valid, dist_data=7FFFF, dist_id=2. Without it: no strobe. A later good reading on sensor 3 (500 us) clears timeout and gives dist_data=500.
- Echo held high >30000 us → MEASURE timeout path as above; scan advances to the next sensor after GAP.
- en=0 asserted during MEASURE of sensor 1 → result for sensor 1 is still reported; busy falls after GAP; no further trig activity.
- rstn pulsed high during TRIG → trig goes to 0 asynchronously, all outputs 0; after release the scan restarts at sensor 0.

Source files
------------

// File: rtl/sr04_scan_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sr04_scan_ctrl
//
// Round-robin scan controller for up to NUM_SENS HC-SR04 ultrasonic sensors
// that share a single echo-width timer. For each enabled sensor in turn it
// fires a trigger pulse, times the echo high phase in microseconds, and
// enforces an echo timeout and a minimum trigger-to-trigger gap. Each
// measurement is published as one tagged 19-bit result.
//
// Optional feature macro: SR04_TIMEOUT_REPORT_EN
//   defined   : a timeout also strobes dist_valid with dist_data = 19'h7FFFF
//               ("out of range") and dist_id = the timed-out sensor.
//   undefined : a timeout only sets the sticky timeout flag.
//
// Ports:
//   clk        in   system clock
//   rstn       in   asynchronous reset, ACTIVE-HIGH despite the name
//   en         in   scan enable; 0 parks the FSM in IDLE once the slot ends
//   sens_mask  in   [NUM_SENS] sensors included in the scan
//   echo       in   [NUM_SENS] raw (asynchronous) echo inputs
//   trig       out  [NUM_SENS] trigger outputs, one-hot or zero
//   dist_data  out  [19] echo high time in us, saturating
//   dist_id    out  [3]  sensor index that produced dist_data
//   dist_valid out  one-cycle result strobe
//   timeout    out  sticky timeout flag, cleared by the next good result
//   busy       out  high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module sr04_scan_ctrl #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int NUM_SENS   = 4,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 30_000,
  parameter int GAP_US     = 60_000
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                en,
  input  logic [NUM_SENS-1:0] sens_mask,
  input  logic [NUM_SENS-1:0] echo,
  output logic [NUM_SENS-1:0] trig,
  output logic [18:0]         dist_data,
  output logic [2:0]          dist_id,
  output logic                dist_valid,
  output logic                timeout,
  output logic                busy
);

  localparam int DIV   = (CLK_FREQ / 1_000_000 < 1) ? 1 : CLK_FREQ / 1_000_000;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SEL_W = (NUM_SENS > 1) ? $clog2(NUM_SENS) : 1;
  localparam int CNT_W = 24;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_US - 1);
  localparam logic [CNT_W-1:0] TMO_LIM   = CNT_W'(TIMEOUT_US);
  localparam logic [CNT_W-1:0] GAP_LIM   = CNT_W'(GAP_US);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] DATA_MAX  = CNT_W'(19'h7FFFF);
  localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(NUM_SENS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_STORE,
    S_GAP
  } state_t;

  state_t state, state_nxt;

  // ---------------------------------------------------------------------------
  // 1 us tick divider. With DIV == 1 the counter stays at zero and the tick is
  // asserted every clock.
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt;
  logic             us_tick;

  // NOTE: rstn is active-high here, so the sensitivity list uses posedge rstn.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign us_tick = (div_cnt == DIV_LAST);

  // ---------------------------------------------------------------------------
  // Echo synchronisers: two flops for metastability, a third copy for edges.
  // Keeping the third stage per bit means a change of sel never fabricates an
  // edge from the previously selected sensor.
  // ---------------------------------------------------------------------------
  logic [NUM_SENS-1:0] echo_s1, echo_s2, echo_s3;
  logic [SEL_W-1:0]    sel, ptr;
  logic                echo_sel, echo_rise, echo_fall;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      echo_s1 <= '0;
      echo_s2 <= '0;
      echo_s3 <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the old value of
      // the previous stage, which is what makes this a three-deep pipeline.
      echo_s1 <= echo;
      echo_s2 <= echo_s1;
      echo_s3 <= echo_s2;
    end
  end

  assign echo_sel  = echo_s2[sel];
  assign echo_rise = echo_s2[sel] & ~echo_s3[sel];
  assign echo_fall = ~echo_s2[sel] & echo_s3[sel];

  // ---------------------------------------------------------------------------
  // Next-sensor arbiter: first set mask bit at or after ptr, wrapping. Walking
  // the offsets from high to low lets the smallest offset win.
  // ---------------------------------------------------------------------------
  logic [SEL_W-1:0] pick;
  logic [SEL_W-1:0] idx_c;
  logic             found;

  always_comb begin
    // NOTE: every combinational output is given a default first so that no
    // path through the block can infer a latch.
    pick  = '0;
    found = 1'b0;
    idx_c = '0;
    for (int i = NUM_SENS - 1; i >= 0; i--) begin
      idx_c = SEL_W'((int'(ptr) + i) % NUM_SENS);
      if (sens_mask[idx_c]) begin
        pick  = idx_c;
        found = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register plus next-state / control decode.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] us_cnt, gap_cnt;
  logic load_sel, cnt_clr, us_clr, us_inc, do_store, do_tmo, ptr_adv;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load_sel  = 1'b0;
    cnt_clr   = 1'b0;
    us_clr    = 1'b0;
    us_inc    = 1'b0;
    do_store  = 1'b0;
    do_tmo    = 1'b0;
    ptr_adv   = 1'b0;
    case (state)
      S_IDLE: begin
        if (en && found) begin
          load_sel  = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = S_TRIG;
        end
      end
      S_TRIG: begin
        if (us_tick) begin
          if (us_cnt >= TRIG_LAST) begin
            us_clr    = 1'b1;
            state_nxt = S_WAIT_RISE;
          end else begin
            us_inc = 1'b1;
          end
        end
      end
      S_WAIT_RISE: begin
        // An edge beats a simultaneous timeout.
        if (echo_rise) begin
          us_clr    = 1'b1;
          state_nxt = S_MEASURE;
        end else if (us_cnt >= TMO_LIM) begin
          do_tmo    = 1'b1;
          state_nxt = S_GAP;
        end else if (us_tick) begin
          us_inc = 1'b1;
        end
      end
      S_MEASURE: begin
        if (echo_fall) begin
          state_nxt = S_STORE;
        end else if (us_cnt >= TMO_LIM) begin
          do_tmo    = 1'b1;
          state_nxt = S_GAP;
        end else if (us_tick && echo_sel) begin
          us_inc = 1'b1;
        end
      end
      S_STORE: begin
        do_store  = 1'b1;
        state_nxt = S_GAP;
      end
      S_GAP: begin
        if (gap_cnt >= GAP_LIM) begin
          ptr_adv   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: counters, pointer, result registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      us_cnt     <= '0;
      gap_cnt    <= '0;
      sel        <= '0;
      ptr        <= '0;
      dist_data  <= '0;
      dist_id    <= '0;
      dist_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      dist_valid <= 1'b0;

      if (cnt_clr || us_clr) begin
        us_cnt <= '0;
      end else if (us_inc && us_cnt != CNT_MAX) begin
        us_cnt <= us_cnt + 1'b1;
      end

      // gap_cnt measures time since trigger start, so it runs in every
      // non-idle state regardless of what the echo timer is doing.
      if (cnt_clr) begin
        gap_cnt <= '0;
      end else if (state != S_IDLE && us_tick && gap_cnt != CNT_MAX) begin
        gap_cnt <= gap_cnt + 1'b1;
      end

      if (load_sel) begin
        sel <= pick;
      end

      if (ptr_adv) begin
        ptr <= (sel == SEL_LAST) ? '0 : sel + 1'b1;
      end

      if (do_store) begin
        dist_valid <= 1'b1;
        dist_data  <= (us_cnt > DATA_MAX) ? 19'h7FFFF : us_cnt[18:0];
        dist_id    <= 3'(sel);
        timeout    <= 1'b0;
      end

      if (do_tmo) begin
        timeout <= 1'b1;
`ifdef SR04_TIMEOUT_REPORT_EN
        dist_valid <= 1'b1;
        dist_data  <= 19'h7FFFF;
        dist_id    <= 3'(sel);
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs decoded from state so reset removes the trigger asynchronously.
  // ---------------------------------------------------------------------------
  always_comb begin
    trig = '0;
    if (state == S_TRIG) begin
      trig[sel] = 1'b1;
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_sr04_scan_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for sr04_scan_ctrl. Time constants are scaled down so a
// full scan fits in a short run; the 2 MHz clock exercises the us divider.
module tb_sr04_scan_ctrl;

  localparam int CLK_FREQ = 2_000_000;
  localparam int DIV      = CLK_FREQ / 1_000_000;
  localparam int NS       = 4;
  localparam int TRIG_US  = 10;
  localparam int TMO_US   = 300;
  localparam int GAP_US   = 800;
  localparam int ECHO_DLY = 20;
  localparam int SLOT_BUDGET = (GAP_US + 50) * DIV * 2;

  localparam int M_NORMAL = 0;
  localparam int M_NEVER  = 1;
  localparam int M_STUCK  = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic          en;
  logic [NS-1:0] sens_mask;
  logic [NS-1:0] echo;
  logic [NS-1:0] trig;
  logic [18:0]   dist_data;
  logic [2:0]    dist_id;
  logic          dist_valid;
  logic          timeout;
  logic          busy;

  sr04_scan_ctrl #(
    .CLK_FREQ  (CLK_FREQ),
    .NUM_SENS  (NS),
    .TRIG_US   (TRIG_US),
    .TIMEOUT_US(TMO_US),
    .GAP_US    (GAP_US)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .sens_mask (sens_mask),
    .echo      (echo),
    .trig      (trig),
    .dist_data (dist_data),
    .dist_id   (dist_id),
    .dist_valid(dist_valid),
    .timeout   (timeout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int obs, input int exp, input int tol);
    int diff;
    n_checks++;
    diff = (obs > exp) ? obs - exp : exp - obs;
    if (diff > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d", tag, obs, exp, tol, cyc);
    end
  endtask

  // Scoreboard: expectations are pushed when the echo stimulus is applied and
  // popped when the DUT strobes a result.
  typedef struct {
    int id;
    int data;
    int tol;
    int tmo;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_strobes = 0;

  always @(negedge clk) begin
    if (!rstn && dist_valid) begin
      n_strobes++;
      if (sb_q.size() == 0) begin
        check("unexpected_strobe", 1, 0, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("dist_id", int'(dist_id), mon_e.id, 0);
        check("dist_data", int'(dist_data), mon_e.data, mon_e.tol);
        check("timeout_at_strobe", int'(timeout), mon_e.tmo, 0);
      end
    end
  end

  int last_start = -1;

  // Waits for the next trigger, checks its target, width and spacing, then
  // plays the sensor's echo response.
  task automatic run_slot(input int exp_id, input int mode, input int width_us, input bit drop_en);
    int            n;
    int            t0;
    int            s0;
    logic [NS-1:0] oh;
    oh = NS'(1) << exp_id;
    n  = 0;
    while (trig == '0 && n < SLOT_BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (trig == '0) begin
      check("trig_start_wait", 0, 1, 0);
      return;
    end
    t0 = cyc;
    check("trig_select", int'(trig), int'(oh), 0);
    if (last_start >= 0) check("trig_period", t0 - last_start, GAP_US * DIV + 2, DIV + 1);
    last_start = t0;
    n = 0;
    while (trig != '0 && n < SLOT_BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("trig_width", n, TRIG_US * DIV, DIV);

    repeat (ECHO_DLY) @(negedge clk);
    s0 = n_strobes;
    if (mode == M_NORMAL) begin
      echo[exp_id] = 1'b1;
      if (drop_en) begin
        repeat (10) @(negedge clk);
        en = 1'b0;
        repeat (width_us * DIV - 10) @(negedge clk);
      end else begin
        repeat (width_us * DIV) @(negedge clk);
      end
      echo[exp_id] = 1'b0;
      sb_q.push_back('{exp_id, width_us, 1, 0});
      n = 0;
      while (n_strobes == s0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("result_strobe", n_strobes - s0, 1, 0);
      check("timeout_cleared", int'(timeout), 0, 0);
    end else begin
`ifdef SR04_TIMEOUT_REPORT_EN
      sb_q.push_back('{exp_id, 32'h7FFFF, 0, 1});
`endif
      if (mode == M_STUCK) echo[exp_id] = 1'b1;
      repeat ((TMO_US + 10) * DIV) @(negedge clk);
      check("timeout_flag", int'(timeout), 1, 0);
`ifdef SR04_TIMEOUT_REPORT_EN
      check("timeout_strobe", n_strobes - s0, 1, 0);
`else
      check("timeout_no_strobe", n_strobes - s0, 0, 0);
`endif
      echo[exp_id] = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_trig"},       int'(trig),       0, 0);
    check({tag, "_dist_data"},  int'(dist_data),  0, 0);
    check({tag, "_dist_id"},    int'(dist_id),    0, 0);
    check({tag, "_dist_valid"}, int'(dist_valid), 0, 0);
    check({tag, "_timeout"},    int'(timeout),    0, 0);
    check({tag, "_busy"},       int'(busy),       0, 0);
  endtask

  initial begin
    int n;
    int act;
    rstn      = 1'b1;
    en        = 1'b0;
    sens_mask = 4'b1111;
    echo      = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rstn = 1'b0;

    // en=0 keeps the scan parked.
    repeat (50) @(negedge clk);
    check("idle_en0_busy", int'(busy), 0, 0);
    check("idle_en0_trig", int'(trig), 0, 0);

    // All-zero mask keeps the scan parked even with en=1.
    sens_mask = '0;
    en        = 1'b1;
    repeat (50) @(negedge clk);
    check("idle_mask0_busy", int'(busy), 0, 0);
    check("idle_mask0_trig", int'(trig), 0, 0);

    // Full mask: 0,1,2,3 with sensor 2 silent and sensor 3 clearing timeout.
    sens_mask = 4'b1111;
    run_slot(0, M_NORMAL, 116, 1'b0);
    run_slot(1, M_NORMAL, 50,  1'b0);
    run_slot(2, M_NEVER,  0,   1'b0);
    run_slot(3, M_NORMAL, 250, 1'b0);

    // Mask 1010: only sensors 1 and 3, with a stuck-high echo on sensor 1.
    sens_mask = 4'b1010;
    run_slot(1, M_NORMAL, 80,  1'b0);
    run_slot(3, M_NORMAL, 200, 1'b0);
    run_slot(1, M_STUCK,  0,   1'b0);
    run_slot(3, M_NORMAL, 10,  1'b0);

    // en dropped during MEASURE: the result still arrives, then the scan parks.
    run_slot(1, M_NORMAL, 60, 1'b1);
    n = 0;
    while (busy && n < SLOT_BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("busy_fall_after_gap", int'(busy), 0, 0);
    act = 0;
    repeat (2 * GAP_US * DIV) begin
      @(negedge clk);
      if (trig != '0 || busy) act++;
    end
    check("parked_after_en_drop", act, 0, 0);
    last_start = -1;

    // Reset in the middle of a trigger pulse.
    sens_mask = 4'b1111;
    en        = 1'b1;
    n = 0;
    while (trig == '0 && n < SLOT_BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("resume_trig_sensor2", int'(trig), 4, 0);
    @(negedge clk);
    #2 rstn = 1'b1;
    #1 check_all_zero("mid_trig_reset");
    repeat (3) @(negedge clk);
    rstn = 1'b0;

    // Scan restarts at sensor 0.
    run_slot(0, M_NORMAL, 116, 1'b0);
    run_slot(1, M_NORMAL, 290, 1'b0);

    check("scoreboard_drained", sb_q.size(), 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
